// File: rtl/bec_result_reader_if.sv
// Command/response channel between the management SoC logic analyzer and
// the BEC result reader. The SoC side is the master (issues commands); the
// reader is the slave (returns tagged response chunks).
interface bec_result_reader_if #(
  parameter int CHUNK = 82,
  parameter int TAG_W = 14
);
  logic             rd_en;
  logic             cmd_valid;
  logic [7:0]       cmd_sel;
  logic             rsp_valid;
  logic [CHUNK-1:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output rd_en,
    output cmd_valid,
    output cmd_sel,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_tag
  );

  modport slave (
    input  rd_en,
    input  cmd_valid,
    input  cmd_sel,
    output rsp_valid,
    output rsp_data,
    output rsp_tag
  );
endinterface

// File: rtl/bec_result_reader.sv
// BEC result reader: captures the W/Z results of the BEC core into shadow
// registers and serves them as tagged chunks over the LA command path.
// A result set is retired only by an explicit release after all four
// chunks have been read.
module bec_result_reader #(
  parameter int WIDTH = 163,
  parameter int CHUNK = 82,
  parameter int TAG_W = 14
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_wout,
  input  logic [WIDTH-1:0] core_zout,
  bec_result_reader_if.slave la,
  output logic             full,
  output logic [3:0]       rd_mask,
  output logic             read_done,
  output logic             overrun
);

  // Low chunk width; the low chunk is zero-extended up to CHUNK bits.
  localparam int LO_W = WIDTH - CHUNK;

  localparam logic [7:0] CMD_RELEASE = 8'h10;

  localparam logic [TAG_W-1:0] TAG_READ_BASE = TAG_W'(14'h3100);
  localparam logic [TAG_W-1:0] TAG_REL_OK    = TAG_W'(14'h3500);
  localparam logic [TAG_W-1:0] TAG_REL_NAK   = TAG_W'(14'h3E00);
  localparam logic [TAG_W-1:0] TAG_BAD_CMD   = TAG_W'(14'h3FFF);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             cmd_prev_q;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [3:0]       rd_mask_q, rd_mask_d;
  logic             overrun_q, overrun_d;
  logic             read_done_q, read_done_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [CHUNK-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic             is_full;
  logic             accept;
  logic             read_cmd;
  logic             release_cmd;
  logic             release_ok;
  logic             capture;
  logic [1:0]       chunk_idx;

  // Chunk views of the shadow registers, indexed by cmd_sel[3:2]:
  // 0 W-hi, 1 W-lo, 2 Z-hi, 3 Z-lo.
  logic [CHUNK-1:0] chunk_data [4];
  logic [TAG_W-1:0] chunk_tag  [4];

  assign chunk_data[0] = w_q[WIDTH-1 -: CHUNK];
  assign chunk_data[1] = CHUNK'(w_q[LO_W-1:0]);
  assign chunk_data[2] = z_q[WIDTH-1 -: CHUNK];
  assign chunk_data[3] = CHUNK'(z_q[LO_W-1:0]);

  // Command decode. Only a rising edge of cmd_valid (with rd_en high)
  // counts, so a strobe held high by the SoC executes exactly once.
  assign is_full     = (state_q == ST_FULL);
  assign accept      = la.cmd_valid & ~cmd_prev_q & la.rd_en;
  assign chunk_idx   = la.cmd_sel[3:2];
  assign read_cmd    = accept & is_full & (la.cmd_sel[7:4] == 4'h0) &
                       (la.cmd_sel[1:0] == 2'b00);
  assign release_cmd = accept & is_full & (la.cmd_sel == CMD_RELEASE);
  assign release_ok  = release_cmd & (rd_mask_q == 4'hF);
  // A new result lands only when the slot is free or being freed right now;
  // otherwise the held set is protected and the loss is flagged as overrun.
  assign capture     = core_done & (~is_full | release_ok);

  // Per-chunk read tracking and tag generation.
  for (genvar gi = 0; gi < 4; gi++) begin : g_chunk
    assign chunk_tag[gi] = TAG_READ_BASE + (TAG_W'(gi) << 8);
    assign rd_mask_d[gi] = (capture | release_ok) ? 1'b0 :
                           (rd_mask_q[gi] | (read_cmd & (chunk_idx == 2'(gi))));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_EMPTY;
      cmd_prev_q  <= 1'b0;
      w_q         <= '0;
      z_q         <= '0;
      rd_mask_q   <= '0;
      overrun_q   <= 1'b0;
      read_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_prev_q  <= la.cmd_valid;
      w_q         <= w_d;
      z_q         <= z_d;
      rd_mask_q   <= rd_mask_d;
      overrun_q   <= overrun_d;
      read_done_q <= read_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  // Next state: capture always leaves us FULL; a clean release empties.
  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = ST_FULL;
    end else if (release_ok) begin
      state_d = ST_EMPTY;
    end
  end

  // Shadow registers, overrun flag and release pulse.
  always_comb begin
    w_d         = w_q;
    z_d         = z_q;
    overrun_d   = overrun_q;
    read_done_d = release_ok;
    if (capture) begin
      w_d = core_wout;
      z_d = core_zout;
    end else if (release_ok) begin
      w_d = '0;
      z_d = '0;
    end
    if (release_ok) begin
      overrun_d = 1'b0;
    end else if (core_done & is_full) begin
      overrun_d = 1'b1;
    end
  end

  // Response formation: registered one cycle after acceptance; payload and
  // tag hold their value between responses. Reads use the pre-capture data.
  always_comb begin
    rsp_valid_d = accept;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    if (accept) begin
      rsp_data_d = '0;
      rsp_tag_d  = '0;
      if (read_cmd) begin
        rsp_data_d = chunk_data[chunk_idx];
        rsp_tag_d  = chunk_tag[chunk_idx];
      end else if (release_cmd) begin
        rsp_tag_d = release_ok ? TAG_REL_OK : TAG_REL_NAK;
      end else if (is_full) begin
        rsp_tag_d = TAG_BAD_CMD;
      end
    end
  end

  // Output drive from the registered state.
  always_comb begin
    full         = (state_q == ST_FULL);
    rd_mask      = rd_mask_q;
    read_done    = read_done_q;
    overrun      = overrun_q;
    la.rsp_valid = rsp_valid_q;
    la.rsp_data  = rsp_data_q;
    la.rsp_tag   = rsp_tag_q;
  end

endmodule
